alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter ROUND_ROBIN, default 1, 1 = round-robin grant between requesters; 0 = fixed priority, requester 0 always wins.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 r0_valid / r1_valid  input  1  requester 0/1 has an operation pending.
REQ-005 r0_ready / r1_ready  output  1  requester 0/1 request accepted this cycle.
REQ-006 r0_op / r1_op  input  4  ALU operation code (0001 add … 1010 lui).
REQ-007 r0_a, r0_b / r1_a, r1_b  input  32 each  operand1, operand2.
REQ-008 alu_operation  output  4  drives shared ALU operation port.
REQ-009 alu_operand1, alu_operand2  output  32 each  drive shared ALU operands.
REQ-010 alu_result  input  32  shared ALU result (combinational).
REQ-011 alu_zero  input  1  shared ALU zero flag.
REQ-012 rsp_valid  output  1  response held for consumer.
REQ-013 rsp_ready  input  1  consumer accepts response.
REQ-014 rsp_id  output  1  requester that owns the response.
REQ-015 rsp_result  output  32  registered ALU result.
REQ-016 rsp_zero  output  1  registered zero flag.
REQ-017 rsp_illegal  output  1  op code outside 0001-1010.

Function
REQ-018 FSM states IDLE, EXEC, RESP; exactly one active.
REQ-019 IDLE: if r0_valid or r1_valid, assert ready to exactly one winner combinationally; winner's op/operands latched at edge; state -> EXEC.
REQ-020 IDLE with neither valid: no ready, stay IDLE.
REQ-021 Round-robin: both valid -> grant requester not granted last; last_grant updates only on accepted handshake.
REQ-022 ROUND_ROBIN=0: both valid -> requester 0 granted.
REQ-023 Ready never asserted outside IDLE; never both readys same cycle.
REQ-024 EXEC: alu_operation/operands driven from latched registers; at edge capture alu_result -> rsp_result, alu_zero -> rsp_zero, winner -> rsp_id; state -> RESP.
REQ-025 Outside EXEC, alu_operation = 0000 and both ALU operands = 0.
REQ-026 RESP: rsp_valid = 1; rsp_id/result/zero/illegal stable until rsp_ready sampled high; then -> IDLE.
REQ-027 Latency: handshake edge N -> rsp_valid high from edge N+2; minimum 3 cycles per operation.
REQ-028 Illegal op (0000, 1011-1111): accepted normally; rsp_result = 0, rsp_zero = alu_zero, rsp_illegal = 1; otherwise rsp_illegal = 0.
REQ-029 Request dropped before grant (valid deasserted) imposes no state change; no requester starves: under continuous dual requests with ROUND_ROBIN=1, grants alternate strictly.
REQ-030 Input operands/op changing after handshake shall not affect the in-flight operation.

Reset
REQ-031 reset high at edge: state IDLE, rsp_valid 0, rsp_id 0, rsp_result 0, rsp_zero 0, rsp_illegal 0, latched op/operands 0, last_grant = 1 (requester 0 wins first tie).
REQ-032 Reset in EXEC or RESP abandons the operation; no response emitted; readys low during the reset cycle.
REQ-033 Reset overrides all other inputs in the same cycle.

Verification
REQ-034 r0 add 5+7 alone -> r0_ready cycle 0, rsp_valid at cycle 2, rsp_id 0, rsp_result 12, rsp_zero 0.
REQ-035 Both valid continuously after reset, rsp_ready=1 -> grants r0, r1, r0, r1; one response per 3 cycles, ids match.
REQ-036 r1 sub 9-9 with rsp_ready=0 for 5 cycles -> rsp_valid, result 0, zero 1 held stable; no ready asserted until release.
REQ-037 r0 op 1111 operands 3,3 -> rsp_illegal 1, rsp_result 0, rsp_zero 1.
REQ-038 ROUND_ROBIN=0, both valid -> r0 granted every time; r1 waits until r0_valid low.
REQ-039 Reset asserted in EXEC -> next cycle IDLE, rsp_valid 0, next tie granted to r0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU.
// One operation in flight at a time: IDLE grants, EXEC drives the ALU,
// RESP holds the registered response until the consumer takes it.
module alu_arbiter #(
  parameter int unsigned ROUND_ROBIN = 1,
  localparam int unsigned DATA_W = 32,
  localparam int unsigned OP_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [OP_W-1:0]   r0_op,
  input  logic [DATA_W-1:0] r0_a,
  input  logic [DATA_W-1:0] r0_b,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [OP_W-1:0]   r1_op,
  input  logic [DATA_W-1:0] r1_a,
  input  logic [DATA_W-1:0] r1_b,
  output logic [OP_W-1:0]   alu_operation,
  output logic [DATA_W-1:0] alu_operand1,
  output logic [DATA_W-1:0] alu_operand2,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_illegal
);

  localparam logic [OP_W-1:0] OP_FIRST = OP_W'(1);
  localparam logic [OP_W-1:0] OP_LAST  = OP_W'(10);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;

  logic [OP_W-1:0]     r_op;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic                r_grant;
  logic                r_last_grant;

  logic                r_rsp_valid;
  logic                r_rsp_id;
  logic [DATA_W-1:0]   r_rsp_result;
  logic                r_rsp_zero;
  logic                r_rsp_illegal;

  logic                w_any_valid;
  logic                w_pick1;
  logic                w_accept;
  logic                w_illegal;

  assign w_any_valid = r0_valid | r1_valid;

  // Winner selection: a tie goes to the requester not served last (or to r0 in fixed mode)
  always_comb begin
    w_pick1 = r1_valid;
    if (r0_valid && r1_valid) begin
      w_pick1 = (ROUND_ROBIN != 0) ? ~r_last_grant : 1'b0;
    end
  end

  assign w_accept  = (r_state == S_IDLE) && !reset && w_any_valid;
  assign w_illegal = (r_op < OP_FIRST) || (r_op > OP_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state, request handshakes and shared-ALU drive
  always_comb begin
    w_next_state  = r_state;
    r0_ready      = 1'b0;
    r1_ready      = 1'b0;
    alu_operation = '0;
    alu_operand1  = '0;
    alu_operand2  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          r0_ready     = ~w_pick1;
          r1_ready     = w_pick1;
          w_next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_operation = r_op;
        alu_operand1  = r_a;
        alu_operand2  = r_b;
        w_next_state  = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Latch the winning request and capture the ALU result into the response
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op          <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_grant       <= 1'b0;
      r_last_grant  <= 1'b1;
      r_rsp_valid   <= 1'b0;
      r_rsp_id      <= 1'b0;
      r_rsp_result  <= '0;
      r_rsp_zero    <= 1'b0;
      r_rsp_illegal <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op         <= w_pick1 ? r1_op : r0_op;
        r_a          <= w_pick1 ? r1_a  : r0_a;
        r_b          <= w_pick1 ? r1_b  : r0_b;
        r_grant      <= w_pick1;
        r_last_grant <= w_pick1;
      end
      if (r_state == S_EXEC) begin
        r_rsp_valid   <= 1'b1;
        r_rsp_id      <= r_grant;
        r_rsp_result  <= w_illegal ? DATA_W'(0) : alu_result;
        r_rsp_zero    <= alu_zero;
        r_rsp_illegal <= w_illegal;
      end else if ((r_state == S_RESP) && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign rsp_valid   = r_rsp_valid;
  assign rsp_id      = r_rsp_id;
  assign rsp_result  = r_rsp_result;
  assign rsp_zero    = r_rsp_zero;
  assign rsp_illegal = r_rsp_illegal;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: instance 0 round-robin, instance 1 fixed priority.
// Expected responses are queued at grant time and popped by a monitor.
module tb_alu_arbiter;

  typedef struct packed {
    logic        inst;
    logic        id;
    logic [31:0] res;
    logic        zero;
    logic        ill;
  } exp_t;

  logic        clk;
  logic [1:0]  reset;
  logic [1:0]  r0_valid, r1_valid, r0_ready, r1_ready;
  logic [3:0]  r0_op [2];
  logic [3:0]  r1_op [2];
  logic [31:0] r0_a [2];
  logic [31:0] r0_b [2];
  logic [31:0] r1_a [2];
  logic [31:0] r1_b [2];
  logic [3:0]  alu_operation [2];
  logic [31:0] alu_operand1 [2];
  logic [31:0] alu_operand2 [2];
  logic [31:0] alu_result [2];
  logic [1:0]  alu_zero;
  logic [1:0]  rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_illegal;
  logic [31:0] rsp_result [2];

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference ALU shared by both instances
  function automatic logic [31:0] tb_alu(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      4'd1:    return a + b;
      4'd2:    return a - b;
      4'd3:    return a & b;
      4'd4:    return a | b;
      4'd5:    return a ^ b;
      4'd10:   return b << 12;
      default: return a - b;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    alu_arbiter #(.ROUND_ROBIN((g == 0) ? 1 : 0)) u_dut (
      .clk          (clk),
      .reset        (reset[g]),
      .r0_valid     (r0_valid[g]),
      .r0_ready     (r0_ready[g]),
      .r0_op        (r0_op[g]),
      .r0_a         (r0_a[g]),
      .r0_b         (r0_b[g]),
      .r1_valid     (r1_valid[g]),
      .r1_ready     (r1_ready[g]),
      .r1_op        (r1_op[g]),
      .r1_a         (r1_a[g]),
      .r1_b         (r1_b[g]),
      .alu_operation(alu_operation[g]),
      .alu_operand1 (alu_operand1[g]),
      .alu_operand2 (alu_operand2[g]),
      .alu_result   (alu_result[g]),
      .alu_zero     (alu_zero[g]),
      .rsp_valid    (rsp_valid[g]),
      .rsp_ready    (rsp_ready[g]),
      .rsp_id       (rsp_id[g]),
      .rsp_result   (rsp_result[g]),
      .rsp_zero     (rsp_zero[g]),
      .rsp_illegal  (rsp_illegal[g])
    );
    assign alu_result[g] = tb_alu(alu_operation[g], alu_operand1[g], alu_operand2[g]);
    assign alu_zero[g]   = (alu_result[g] == 32'd0);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int g, input logic id, input logic [31:0] res, input logic zero,
                      input logic ill);
    exp_t e;
    e.inst = (g != 0);
    e.id   = id;
    e.res  = res;
    e.zero = zero;
    e.ill  = ill;
    exp_q.push_back(e);
  endtask

  // Response monitor: one pop per accepted response
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!reset[g] && rsp_valid[g] && rsp_ready[g]) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected rsp: inst %0d id %0d result %0h, expected none",
                   g, rsp_id[g], rsp_result[g]);
        end else begin
          mon_e = exp_q.pop_front();
          check("rsp inst", 32'(g), 32'(mon_e.inst));
          check("rsp_id", 32'(rsp_id[g]), 32'(mon_e.id));
          check("rsp_result", rsp_result[g], mon_e.res);
          check("rsp_zero", 32'(rsp_zero[g]), 32'(mon_e.zero));
          check("rsp_illegal", 32'(rsp_illegal[g]), 32'(mon_e.ill));
        end
      end
    end
  end

  task automatic do_reset(input int g);
    @(posedge clk); #1;
    reset[g] = 1'b1;
    r0_valid[g] = 1'b1;
    r1_valid[g] = 1'b1;
    @(negedge clk);
    check("reset r0_ready", 32'(r0_ready[g]), 0);
    check("reset r1_ready", 32'(r1_ready[g]), 0);
    @(posedge clk); #1;
    r0_valid[g] = 1'b0;
    r1_valid[g] = 1'b0;
    check("reset rsp_valid", 32'(rsp_valid[g]), 0);
    check("reset rsp_id", 32'(rsp_id[g]), 0);
    check("reset rsp_result", rsp_result[g], 0);
    check("reset rsp_zero", 32'(rsp_zero[g]), 0);
    check("reset rsp_illegal", 32'(rsp_illegal[g]), 0);
    reset[g] = 1'b0;
    @(negedge clk);
    check("idle r0_ready", 32'(r0_ready[g]), 0);
    check("idle r1_ready", 32'(r1_ready[g]), 0);
    check("idle alu_operation", 32'(alu_operation[g]), 0);
    check("idle alu_operand1", alu_operand1[g], 0);
  endtask

  // Single request: handshake, queue the expectation, then scramble inputs
  task automatic issue(input int g, input bit req, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit do_push, input logic [31:0] e_res,
                       input logic e_zero, input logic e_ill);
    @(posedge clk); #1;
    if (req) begin
      r1_valid[g] = 1'b1; r1_op[g] = op; r1_a[g] = a; r1_b[g] = b;
    end else begin
      r0_valid[g] = 1'b1; r0_op[g] = op; r0_a[g] = a; r0_b[g] = b;
    end
    @(negedge clk);
    check("issue r0_ready", 32'(r0_ready[g]), 32'(!req));
    check("issue r1_ready", 32'(r1_ready[g]), 32'(req));
    if (do_push) push(g, req, e_res, e_zero, e_ill);
    @(posedge clk); #1;
    r0_valid[g] = 1'b0; r1_valid[g] = 1'b0;
    r0_op[g] = 4'd5; r0_a[g] = 32'hDEAD_BEEF; r0_b[g] = 32'h1234_5678;
    r1_op[g] = 4'd5; r1_a[g] = 32'hCAFE_F00D; r1_b[g] = 32'h0BAD_0BAD;
  endtask

  task automatic wait_drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("drain pending", 32'(exp_q.size()), 0);
  endtask

  initial begin
    reset     = 2'b11;
    r0_valid  = '0;
    r1_valid  = '0;
    rsp_ready = 2'b11;
    for (int i = 0; i < 2; i++) begin
      r0_op[i] = '0; r0_a[i] = '0; r0_b[i] = '0;
      r1_op[i] = '0; r1_a[i] = '0; r1_b[i] = '0;
    end

    // Lone add: latency and operand isolation after handshake
    do_reset(0);
    issue(0, 1'b0, 4'd1, 32'd5, 32'd7, 1'b1, 32'd12, 1'b0, 1'b0);
    @(negedge clk);
    check("exec alu_operation", 32'(alu_operation[0]), 1);
    check("exec alu_operand1", alu_operand1[0], 5);
    check("exec alu_operand2", alu_operand2[0], 7);
    check("exec r0_ready", 32'(r0_ready[0]), 0);
    @(negedge clk);
    check("latency rsp_valid", 32'(rsp_valid[0]), 1);
    wait_drain();

    // Continuous dual requests alternate r0, r1, r0, r1
    do_reset(0);
    @(posedge clk); #1;
    r0_valid[0] = 1'b1; r0_op[0] = 4'd1; r0_a[0] = 32'd1;  r0_b[0] = 32'd2;
    r1_valid[0] = 1'b1; r1_op[0] = 4'd2; r1_a[0] = 32'd10; r1_b[0] = 32'd4;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rr r0_ready", 32'(r0_ready[0]), 32'((k % 2) == 0));
      check("rr r1_ready", 32'(r1_ready[0]), 32'((k % 2) == 1));
      if ((k % 2) == 0) push(0, 1'b0, 32'd3, 1'b0, 1'b0);
      else              push(0, 1'b1, 32'd6, 1'b0, 1'b0);
      @(negedge clk);
      check("rr exec ready", 32'({r0_ready[0], r1_ready[0]}), 0);
      @(negedge clk);
      check("rr resp ready", 32'({r0_ready[0], r1_ready[0]}), 0);
    end
    @(posedge clk); #1;
    r0_valid[0] = 1'b0; r1_valid[0] = 1'b0;
    wait_drain();

    // Response held under backpressure while r0 waits
    @(posedge clk); #1;
    rsp_ready[0] = 1'b0;
    r1_valid[0] = 1'b1; r1_op[0] = 4'd2; r1_a[0] = 32'd9; r1_b[0] = 32'd9;
    @(negedge clk);
    check("hold r1_ready", 32'(r1_ready[0]), 1);
    check("hold r0_ready", 32'(r0_ready[0]), 0);
    push(0, 1'b1, 32'd0, 1'b1, 1'b0);
    @(posedge clk); #1;
    r1_valid[0] = 1'b0;
    r0_valid[0] = 1'b1; r0_op[0] = 4'd1; r0_a[0] = 32'd2; r0_b[0] = 32'd3;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold rsp_valid", 32'(rsp_valid[0]), 1);
      check("hold rsp_id", 32'(rsp_id[0]), 1);
      check("hold rsp_result", rsp_result[0], 0);
      check("hold rsp_zero", 32'(rsp_zero[0]), 1);
      check("hold r0_ready", 32'(r0_ready[0]), 0);
    end
    @(posedge clk); #1;
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("release r0_ready", 32'(r0_ready[0]), 1);
    push(0, 1'b0, 32'd5, 1'b0, 1'b0);
    @(posedge clk); #1;
    r0_valid[0] = 1'b0;
    wait_drain();

    // Opcode boundaries: illegal 1111 and 0000, legal 1010, add wrap to zero
    issue(0, 1'b0, 4'hF, 32'd3, 32'd3, 1'b1, 32'd0, 1'b1, 1'b1);
    wait_drain();
    issue(0, 1'b0, 4'h0, 32'd5, 32'd2, 1'b1, 32'd0, 1'b0, 1'b1);
    wait_drain();
    issue(0, 1'b1, 4'hA, 32'd0, 32'd1, 1'b1, 32'd4096, 1'b0, 1'b0);
    wait_drain();
    issue(0, 1'b0, 4'h1, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd0, 1'b1, 1'b0);
    wait_drain();

    // Reset during EXEC abandons the operation and restores r0 tie priority
    issue(0, 1'b0, 4'd1, 32'd1, 32'd1, 1'b0, 32'd0, 1'b0, 1'b0);
    reset[0] = 1'b1;
    r1_valid[0] = 1'b1;
    @(negedge clk);
    check("exec-reset r0_ready", 32'(r0_ready[0]), 0);
    check("exec-reset r1_ready", 32'(r1_ready[0]), 0);
    @(posedge clk); #1;
    reset[0] = 1'b0;
    r0_valid[0] = 1'b1; r0_op[0] = 4'd1; r0_a[0] = 32'd4; r0_b[0] = 32'd4;
    r1_valid[0] = 1'b1; r1_op[0] = 4'd2; r1_a[0] = 32'd8; r1_b[0] = 32'd1;
    @(negedge clk);
    check("post-reset rsp_valid", 32'(rsp_valid[0]), 0);
    check("post-reset r0_ready", 32'(r0_ready[0]), 1);
    check("post-reset r1_ready", 32'(r1_ready[0]), 0);
    push(0, 1'b0, 32'd8, 1'b0, 1'b0);
    @(posedge clk); #1;
    r0_valid[0] = 1'b0; r1_valid[0] = 1'b0;
    wait_drain();

    // Fixed priority: r0 wins every tie, r1 served once r0 drops
    do_reset(1);
    @(posedge clk); #1;
    r0_valid[1] = 1'b1; r0_op[1] = 4'd1; r0_a[1] = 32'd1;  r0_b[1] = 32'd1;
    r1_valid[1] = 1'b1; r1_op[1] = 4'd3; r1_a[1] = 32'd12; r1_b[1] = 32'd10;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("fp r0_ready", 32'(r0_ready[1]), 1);
      check("fp r1_ready", 32'(r1_ready[1]), 0);
      push(1, 1'b0, 32'd2, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
    end
    @(posedge clk); #1;
    r0_valid[1] = 1'b0;
    @(negedge clk);
    check("fp r1 served", 32'(r1_ready[1]), 1);
    check("fp r0 idle", 32'(r0_ready[1]), 0);
    push(1, 1'b1, 32'd8, 1'b0, 1'b0);
    @(posedge clk); #1;
    r1_valid[1] = 1'b0;
    wait_drain();

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
